// File: rtl/data_mem_obi.sv
// Word-organised data memory slave with OBI-style req/gnt/rvalid handshake and byte-enabled stores.
// Latency: rvalid LATENCY cycles after the grant; one outstanding transaction, next grant allowed in the rvalid cycle.
// Backpressure: gnt held low while a response is pending; DMEM_STALL_EN adds pseudo-random grant stalls from an LFSR.
module data_mem_obi #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [DATA_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } resp_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  resp_t             resp_q;
  logic              stall;
  logic              in_range;
  logic [AW-1:0]     mem_idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic              unused_addr_lsb;

`ifdef DMEM_STALL_EN
  logic [7:0] lfsr_q;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= 8'hA5;
    else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Every upper address bit takes part so out-of-range accesses never alias
  assign in_range        = ({2'b00, data_addr_i[DATA_WIDTH-1:2]} < DATA_WIDTH'(DEPTH_WORDS));
  assign mem_idx         = data_addr_i[AW+1:2];
  assign unused_addr_lsb = ^data_addr_i[1:0];

  assign data_rvalid_o = (state_q == S_WAIT) && (cnt_q == 2'd0);
  assign data_gnt_o    = data_req_i && ((state_q == S_IDLE) || data_rvalid_o) && !stall;
  assign data_rdata_o  = resp_q.rdata;
  assign data_err_o    = resp_q.err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: ;
      S_WAIT: begin
        if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
        else               state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (data_gnt_o) begin
      state_d = S_WAIT;
      cnt_d   = CNT_INIT;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load data is captured at the grant edge, so a later store cannot disturb it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q <= '0;
    end else if (data_gnt_o) begin
      resp_q.err   <= !in_range;
      resp_q.rdata <= (!data_we_i && in_range) ? mem[mem_idx] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (data_gnt_o && data_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem[mem_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/data_mem_obi.md
# data_mem_obi

Single-port, word-organised data memory slave with an OBI-style req/gnt/rvalid handshake and a configurable response latency. It sits directly downstream of the load/store unit and consumes that unit's `data_req/addr/we/wdata` request stream. It returns `data_gnt`, `data_rvalid` and `data_rdata` to the load/store unit. One transaction is outstanding at most; byte enables support sub-word stores.

## Interface
- `DATA_WIDTH`, 32: data and address width; fixed at 32 (from `riscv_cpu_pkg`).
- `DEPTH_WORDS`, 1024: number of 32-bit words; must be a power of two, at least 2.
- `LATENCY`, 1: cycles from the grant cycle to the `rvalid` cycle; legal range 1..4.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `data_req_i`  in  1  request valid from the LSU.
- `data_gnt_o`  out  1  request accepted this cycle (combinational).
- `data_addr_i`  in  32  byte address; bits [1:0] are ignored.
- `data_we_i`  in  1  1 = store, 0 = load.
- `data_be_i`  in  4  byte enables; applied to stores only.
- `data_wdata_i`  in  32  store data, already lane-aligned.
- `data_rvalid_o`  out  1  one-cycle response pulse.
- `data_rdata_o`  out  32  load data; valid while `data_rvalid_o`=1.
- `data_err_o`  out  1  error flag; valid while `data_rvalid_o`=1.

## Operation
- Word index = `data_addr_i[31:2]`.
- An access is in range when the word index is less than `DEPTH_WORDS`. All upper address bits participate in the range check.
- FSM states:
  - IDLE: no outstanding transaction.
  - WAIT: transaction accepted; a latency counter is running.
- `data_gnt_o` = `data_req_i` AND (state==IDLE OR `data_rvalid_o`==1) AND NOT stall.
- stall is always 0 unless the feature under Configuration is compiled in.
- On a grant edge:
  - In-range store: each byte lane with its `be` bit set takes the matching byte of `data_wdata_i`; other lanes keep their value.
  - In-range load: the addressed word is captured into the response register.
  - Store response data: 0.
  - Out-of-range access: no memory write; response data = 0; error flag = 1.
  - Counter loads `LATENCY-1`; state goes to WAIT.
- In WAIT:
  - The counter decrements each cycle.
  - The cycle in which the counter reads 0 is the `rvalid` cycle.
  - At the end of that cycle: a new grant in the same cycle reloads the counter and stays in WAIT; otherwise state goes to IDLE.
- Back-to-back accepts are allowed in the `rvalid` cycle. Sustained throughput is one transaction per `LATENCY` cycles.
- Load data is captured at the grant edge, so a store granted in the `rvalid` cycle does not alter that response.
- `data_rdata_o` and `data_err_o` hold their last response values between pulses.
- Memory array is not reset. Reading a word never written returns X in simulation.

## Timing
- Reset values: `data_gnt_o`=0 (while `data_req_i`=0), `data_rvalid_o`=0, `data_rdata_o`=0, `data_err_o`=0, state IDLE, counter 0.
- Grant at cycle T gives `rvalid` at T+`LATENCY`.
- With `LATENCY`=1: continuous requests are granted every cycle, and `rvalid` follows each grant by 1 cycle.
- With `LATENCY`>1: `data_gnt_o`=0 during cycles T+1 .. T+`LATENCY`-1, even if `data_req_i`=1.
- `data_req_i` dropped before grant: no side effect. The requester must hold `addr/we/be/wdata` stable until granted.
- Reset asserted mid-transaction: the pending response is discarded with no `rvalid`. A write already granted remains in memory.

## Configuration
- `DMEM_STALL_EN` defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 0xA5 on reset) advances every cycle.
  - stall = `lfsr[0]`; the grant is suppressed whenever stall=1.
  - Purpose: exercise LSU wait-on-grant paths.
- `DMEM_STALL_EN` undefined: no LFSR is present, stall is tied to 0, and the grant rule reduces to the one above.

## Test plan
- `LATENCY`=1: store 0xDEADBEEF to 0x10 with be=1111, then load 0x10 -> `rvalid` one cycle after each grant; `rdata`=0xDEADBEEF, `err`=0.
- Partial store to 0x10: be=0010, wdata=0x0000AB00, then load 0x10 -> 0xDEADABEF.
- `LATENCY`=3: `req` held high for 10 cycles -> grants at cycles 0, 3, 6, 9; `rvalid` at cycles 3, 6, 9; `gnt`=0 in all other cycles.
- Out of range, `DEPTH_WORDS`=1024: store 0x12345678 to 0x1000 -> `err`=1, `rdata`=0; a load from 0x0 returns its previously written value, unaltered.
- Store granted in the `rvalid` cycle of a load from the same address -> the load returns the old data, and a subsequent load returns the new data.
- Reset pulsed in the cycle after a grant (`LATENCY`=2) -> no `rvalid`, all outputs 0; the next request is granted immediately.
